// File: rtl/alu_seq_exec.sv
// Execute-stage ALU with valid/ready handshakes on both sides.
// Single-cycle ops finish on the accept edge; shifts step one bit per cycle.
module alu_seq_exec #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  flush_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [3:0]            alu_control_i,
   input  logic [DATA_WIDTH-1:0] src_a_i,
   input  logic [DATA_WIDTH-1:0] src_b_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [DATA_WIDTH-1:0] result_o,
   output logic                  zero_o,
   output logic                  busy_o
);
   localparam int SW = $clog2(DATA_WIDTH);

   // state  | meaning
   // IDLE   | waiting for an operation, in_ready_o high
   // SHIFT  | iterative shift in progress, one bit per cycle
   // DONE   | result held on result_o until the consumer takes it
   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

   state_t                r_state;
   logic [DATA_WIDTH-1:0] r_work;
   logic [DATA_WIDTH-1:0] r_result;
   logic [SW-1:0]         r_cnt;
   logic [3:0]            r_op;
   logic                  r_zero;
   logic                  r_out_valid;

   logic [DATA_WIDTH-1:0] w_alu;
   logic [DATA_WIDTH-1:0] w_step;
   logic [SW-1:0]         w_shamt;
   logic                  w_is_shift;

   assign w_shamt    = src_b_i[SW-1:0];
   assign w_is_shift = (alu_control_i == 4'h2) || (alu_control_i == 4'h5) ||
                       (alu_control_i == 4'h6);

   // Shift codes only reach w_alu with a zero shift amount, so they pass src_a.
   always_comb begin
      w_alu = '0;
      case (alu_control_i)
         4'h0:                w_alu = src_a_i + src_b_i;
         4'h1:                w_alu = src_a_i - src_b_i;
         4'h2, 4'h5, 4'h6:    w_alu = src_a_i;
         4'h3:                w_alu = DATA_WIDTH'($signed(src_a_i) < $signed(src_b_i));
         4'h4:                w_alu = DATA_WIDTH'(src_a_i < src_b_i);
         4'h7:                w_alu = src_a_i | src_b_i;
         4'h8:                w_alu = src_a_i ^ src_b_i;
         4'h9:                w_alu = src_a_i & src_b_i;
         default:             w_alu = '0;
      endcase
   end

   always_comb begin
      w_step = '0;
      case (r_op)
         4'h2:    w_step = {r_work[DATA_WIDTH-2:0], 1'b0};
         4'h5:    w_step = {1'b0, r_work[DATA_WIDTH-1:1]};
         4'h6:    w_step = {r_work[DATA_WIDTH-1], r_work[DATA_WIDTH-1:1]};
         default: w_step = r_work;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= ST_IDLE;
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_zero      <= 1'b1;
         r_cnt       <= '0;
         r_work      <= '0;
         r_op        <= '0;
      end else if (flush_i) begin
         r_state     <= ST_IDLE;
         r_out_valid <= 1'b0;
         r_cnt       <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid_i) begin
                  if (w_is_shift && (w_shamt != '0)) begin
                     r_work  <= src_a_i;
                     r_cnt   <= w_shamt;
                     r_op    <= alu_control_i;
                     r_state <= ST_SHIFT;
                  end else begin
                     r_result    <= w_alu;
                     r_zero      <= (w_alu == '0);
                     r_out_valid <= 1'b1;
                     r_state     <= ST_DONE;
                  end
               end
            end
            ST_SHIFT: begin
               r_work <= w_step;
               r_cnt  <= r_cnt - SW'(1);
               if (r_cnt == SW'(1)) begin
                  r_result    <= w_step;
                  r_zero      <= (w_step == '0);
                  r_out_valid <= 1'b1;
                  r_state     <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready_i) begin
                  r_out_valid <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign in_ready_o  = (r_state == ST_IDLE) && !rst_i;
   assign busy_o      = (r_state != ST_IDLE) && !rst_i;
   assign out_valid_o = r_out_valid;
   assign result_o    = r_result;
   assign zero_o      = r_zero;
endmodule

// File: tb/tb_alu_seq_exec.sv
// Self-checking bench for alu_seq_exec: a transaction-level model checked every
// cycle, plus directed operations with hand-computed results and latencies.
module tb_alu_seq_exec;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst_i, flush_i, in_valid_i, out_ready_i;
   logic [3:0]    alu_control_i;
   logic [DW-1:0] src_a_i, src_b_i;
   logic          in_ready_o, out_valid_o, zero_o, busy_o;
   logic [DW-1:0] result_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_seq_exec #(.DATA_WIDTH(DW)) dut (
      .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .alu_control_i(alu_control_i), .src_a_i(src_a_i), .src_b_i(src_b_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .result_o(result_o), .zero_o(zero_o), .busy_o(busy_o)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [31:0] r;
      int sh;
      sh = int'(b[4:0]);
      case (c)
         4'h0: r = a + b;
         4'h1: r = a - b;
         4'h2: r = a << sh;
         4'h3: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'h4: r = (a < b) ? 32'd1 : 32'd0;
         4'h5: r = a >> sh;
         4'h6: r = $signed(a) >>> sh;
         4'h7: r = a | b;
         4'h8: r = a ^ b;
         4'h9: r = a & b;
         default: r = 32'd0;
      endcase
      return r;
   endfunction

   // Transaction model: an accepted op occupies the unit until its result is taken.
   logic          m_known = 1'b0;
   logic          m_busy, m_valid, m_zero;
   logic [31:0]   m_result, m_pend;
   int            m_wait;

   always @(posedge clk) begin
      logic [31:0] r;
      int sh;
      if (rst_i) begin
         m_known = 1'b1; m_busy = 1'b0; m_valid = 1'b0;
         m_result = 32'd0; m_zero = 1'b1; m_wait = 0;
      end else if (m_known) begin
         if (flush_i) begin
            m_busy = 1'b0; m_valid = 1'b0; m_wait = 0;
         end else if (!m_busy) begin
            if (in_valid_i) begin
               m_busy = 1'b1;
               r  = ref_alu(alu_control_i, src_a_i, src_b_i);
               sh = int'(src_b_i[4:0]);
               if ((alu_control_i inside {4'h2, 4'h5, 4'h6}) && sh != 0) begin
                  m_wait = sh; m_pend = r;
               end else begin
                  m_result = r; m_zero = (r == 0); m_valid = 1'b1;
               end
            end
         end else if (m_valid) begin
            if (out_ready_i) begin
               m_busy = 1'b0; m_valid = 1'b0;
            end
         end else begin
            m_wait--;
            if (m_wait == 0) begin
               m_result = m_pend; m_zero = (m_pend == 0); m_valid = 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (m_known) begin
         chk("model in_ready", in_ready_o, !m_busy && !rst_i);
         chk("model busy", busy_o, m_busy && !rst_i);
         chk("model out_valid", out_valid_o, m_valid);
         chk("model result", result_o, m_result);
         chk("model zero", zero_o, m_zero);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input string name, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
      int lat, low;
      alu_control_i = c; src_a_i = a; src_b_i = b; in_valid_i = 1'b1;
      step();
      in_valid_i = 1'b0;
      alu_control_i = 4'($urandom_range(0, 15));
      src_a_i = $urandom; src_b_i = $urandom;
      lat = 0; low = 0;
      while (!out_valid_o && lat < 40) begin
         if (!in_ready_o) low++;
         step();
         lat++;
      end
      if (lat >= 40) chk({name, " timeout"}, 32'd0, 32'd1);
      low++;
      chk({name, " result"}, result_o, exp_res);
      chk({name, " zero"}, zero_o, exp_res == 32'd0);
      chk({name, " latency"}, lat, exp_lat);
      step();
      chk({name, " ready_low"}, low, exp_lat + 1);
      chk({name, " back idle"}, in_ready_o, 1'b1);
   endtask

   initial begin
      rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
      alu_control_i = 4'h0; src_a_i = '0; src_b_i = '0;
      step(); step();
      chk("reset result", result_o, 32'd0);
      chk("reset zero", zero_o, 1'b1);
      chk("reset out_valid", out_valid_o, 1'b0);
      chk("reset in_ready", in_ready_o, 1'b0);
      chk("reset busy", busy_o, 1'b0);
      rst_i = 1'b0;
      #1;
      chk("post reset in_ready", in_ready_o, 1'b1);

      run_op("ADD", 4'h0, 32'd5, 32'd7, 32'd12, 0);
      run_op("SUB eq", 4'h1, 32'd5, 32'd5, 32'd0, 0);
      run_op("SUB wrap", 4'h1, 32'd0, 32'd1, 32'hFFFF_FFFF, 0);
      run_op("SLT", 4'h3, 32'hFFFF_FFFF, 32'd1, 32'd1, 0);
      run_op("SLTU", 4'h4, 32'hFFFF_FFFF, 32'd1, 32'd0, 0);
      run_op("code C", 4'hC, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 0);
      run_op("OR", 4'h7, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FFF0, 0);
      run_op("XOR", 4'h8, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00, 0);
      run_op("AND", 4'h9, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0, 0);
      run_op("SRA4", 4'h6, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 4);
      run_op("SRL4", 4'h5, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 4);
      run_op("SLL31", 4'h2, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 31);
      run_op("SRA31 pos", 4'h6, 32'h4000_0000, 32'hFFFF_FFFF, 32'd0, 31);
      run_op("SLL0", 4'h2, 32'hDEAD_BEEF, 32'h0000_0020, 32'hDEAD_BEEF, 0);

      out_ready_i = 1'b0;
      alu_control_i = 4'h0; src_a_i = 32'h10; src_b_i = 32'h20; in_valid_i = 1'b1;
      step();
      in_valid_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("bp out_valid", out_valid_o, 1'b1);
         chk("bp result", result_o, 32'h30);
         chk("bp zero", zero_o, 1'b0);
         chk("bp in_ready", in_ready_o, 1'b0);
         step();
      end
      out_ready_i = 1'b1;
      step();
      chk("bp released valid", out_valid_o, 1'b0);
      chk("bp released busy", busy_o, 1'b0);
      chk("bp result kept", result_o, 32'h30);

      alu_control_i = 4'h2; src_a_i = 32'd3; src_b_i = 32'd10; in_valid_i = 1'b1;
      step();
      in_valid_i = 1'b0;
      step(); step();
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
      chk("flush busy", busy_o, 1'b0);
      begin
         int seen = 0;
         for (int i = 0; i < 15; i++) begin
            if (out_valid_o) seen++;
            step();
         end
         chk("flush no valid", seen, 0);
      end
      chk("flush result kept", result_o, 32'h30);

      flush_i = 1'b1; alu_control_i = 4'h0; src_a_i = 32'd1; src_b_i = 32'd1; in_valid_i = 1'b1;
      step();
      flush_i = 1'b0; in_valid_i = 1'b0;
      chk("flush blocks accept", busy_o, 1'b0);
      step();
      chk("flush blocks valid", out_valid_o, 1'b0);

      out_ready_i = 1'b0;
      alu_control_i = 4'h0; src_a_i = 32'd5; src_b_i = 32'd7; in_valid_i = 1'b1;
      step();
      in_valid_i = 1'b0;
      chk("pre-reset valid", out_valid_o, 1'b1);
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      chk("rst done valid", out_valid_o, 1'b0);
      chk("rst done result", result_o, 32'd0);
      chk("rst done zero", zero_o, 1'b1);
      out_ready_i = 1'b1;
      step(); step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/alu_seq_exec.md
Name: alu_seq_exec

Overview:
Execute-stage ALU. It sits directly downstream of the ALU control decoder and consumes its 4-bit alu_control code plus two operands. Single-cycle operations complete in one cycle. Shifts run iteratively, one bit position per cycle, to save area. Valid/ready handshakes on both sides let the multi-cycle CPU sequencer stall on it.

Parameters:
DATA_WIDTH, 32, operand/result width; shift amount field is $clog2(DATA_WIDTH) bits (5 at default)

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  synchronous active-high reset
flush_i  input  1  synchronous abort of any in-flight operation
in_valid_i  input  1  operands/control presented
in_ready_o  output  1  block can accept an operation
alu_control_i  input  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 SRL, 6 SRA, 7 OR, 8 XOR, 9 AND, A..F result zero
src_a_i  input  DATA_WIDTH  operand A
src_b_i  input  DATA_WIDTH  operand B; bits [4:0] are the shift amount for shifts
out_valid_o  output  1  result available
out_ready_i  input  1  consumer takes result
result_o  output  DATA_WIDTH  registered result
zero_o  output  1  registered, 1 when result_o == 0
busy_o  output  1  state != IDLE

Behaviour:
- Reset (rst_i high at a clock edge): state IDLE, out_valid_o 0, result_o 0, zero_o 1, shift counter 0. in_ready_o is 0 while rst_i is high. rst_i beats flush_i beats all else.
- in_ready_o = (state == IDLE) && !rst_i, combinational. There is no acceptance in SHIFT or DONE, so throughput is at most 1 op per 2 cycles.
- Accept on rising edge with in_valid_i && in_ready_o. alu_control_i, src_a_i and src_b_i are captured. Input changes after acceptance are ignored.
- FSM states: IDLE, SHIFT, DONE.
- IDLE -> DONE for non-shift codes, and for shifts with shamt == 0 (result = src_a). result_o and zero_o are written on the accept edge, so out_valid_o is 1 on the cycle after acceptance.
- IDLE -> SHIFT for codes 2/5/6 with shamt != 0. The working register is loaded with src_a and the counter with shamt. Each SHIFT cycle shifts by 1 and decrements the counter. On the edge where the counter goes 1 -> 0, state moves to DONE with the final value written to result_o/zero_o. Accept-to-out_valid latency is shamt cycles (1..31).
- Shift direction and fill:
  - SLL: shift left, fill 0.
  - SRL: shift right, fill 0.
  - SRA: shift right, replicate bit DATA_WIDTH-1 each step.
- Arithmetic:
  - ADD/SUB wrap modulo 2^DATA_WIDTH; no carry or overflow output.
  - SLT: signed compare. SLTU: unsigned compare. Result is 1 or 0, zero-extended.
  - OR/XOR/AND: bitwise.
  - Codes A..F: result 0, zero_o 1, latency 1.
- DONE:
  - out_valid_o = 1.
  - result_o and zero_o are held stable while out_ready_i is 0, for any number of cycles.
  - On out_valid_o && out_ready_i, go to IDLE and clear out_valid_o next cycle.
  - result_o and zero_o keep their last value in IDLE.
- flush_i high at an edge: state IDLE, out_valid_o 0, counter cleared. A simultaneous in_valid_i is not accepted. result_o is unchanged.
- busy_o = 1 in SHIFT and DONE, 0 in IDLE and during reset.
- Reset mid-shift or mid-DONE: the operation is discarded and no result is delivered.

Test Plan:
- ADD src_a=5, src_b=7, out_ready_i=1 -> out_valid_o 1 cycle after accept, result_o=12, zero_o=0; SUB 5-5 -> result_o=0, zero_o=1; SUB 0-1 -> 0xFFFFFFFF.
- SLT src_a=0xFFFFFFFF, src_b=1 -> result_o=1; SLTU same operands -> result_o=0; code 0xC -> result_o=0, zero_o=1.
- SRA src_a=0x80000000, src_b=0x24 (shamt 4) -> in_ready_o low 5 cycles, out_valid_o 4 cycles after accept, result_o=0xF8000000; SRL same -> 0x08000000; SLL 1 by 31 -> 0x80000000.
- Shift with src_b=0x20 (shamt 0) -> result_o=src_a after 1 cycle; src_b upper bits toggled during SHIFT -> no effect.
- Backpressure: ADD done, out_ready_i low 3 cycles -> out_valid_o, result_o, zero_o stable; in_ready_o 0; handshake on cycle 4 -> IDLE next cycle.
- flush_i asserted during SLL shamt 10 at cycle 3 -> IDLE next cycle, out_valid_o never rises; rst_i in DONE -> out_valid_o 0, result_o 0, zero_o 1.
